// File: rtl/rom_port_arbiter_pkg.sv
// Shared widths, constants and bus types for the instruction ROM port arbiter.
package rom_port_arbiter_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned STREAK_W    = 3;

  localparam int unsigned DM_STREAK_MAX_DEFAULT = 3;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [STREAK_W-1:0]    streak_t;

  localparam inst_t      ZERO_WORD    = INST_W'(0);
  localparam inst_addr_t ZERO_ADDR    = INST_ADDR_W'(0);
  localparam logic       CHIP_ENABLE  = 1'b1;
  localparam logic       CHIP_DISABLE = 1'b0;
  localparam logic       STOP         = 1'b1;
  localparam logic       NO_STOP      = 1'b0;

endpackage : rom_port_arbiter_pkg

// File: rtl/rom_port_arbiter_if.sv
// Requester, ctrl and inst_rom signals seen by the ROM port arbiter.
interface rom_port_arbiter_if;
  import rom_port_arbiter_pkg::*;

  // IF stage fetch side
  logic       if_ce;
  inst_addr_t if_pc;
  inst_t      if_inst;
  logic       if_valid;

  // MEM stage code-space read side
  logic       dm_req;
  inst_addr_t dm_addr;
  logic       dm_gnt;
  inst_t      dm_rdata;
  logic       dm_ack;

  // ctrl side
  logic       flush;
  logic       stallreq_if;

  // inst_rom side
  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_inst;

  // Arbiter view
  modport slave (
    input  if_ce, if_pc, dm_req, dm_addr, flush, rom_inst,
    output if_inst, if_valid, dm_gnt, dm_rdata, dm_ack, stallreq_if,
           rom_ce, rom_addr
  );

  // Requester / ROM / ctrl view
  modport master (
    output if_ce, if_pc, dm_req, dm_addr, flush, rom_inst,
    input  if_inst, if_valid, dm_gnt, dm_rdata, dm_ack, stallreq_if,
           rom_ce, rom_addr
  );

endinterface : rom_port_arbiter_if

// File: rtl/rom_port_arbiter.sv
// Shares the inst_rom read port between IF fetch and MEM code-space reads.
// MEM has priority; a saturating streak counter forces an IF grant after
// DM_STREAK_MAX back-to-back MEM wins so fetch cannot starve.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned DM_STREAK_MAX = DM_STREAK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  rom_port_arbiter_if.slave bus
);

  localparam streak_t STREAK_SAT = STREAK_W'(DM_STREAK_MAX);

  streak_t streak;
  streak_t streak_nxt;
  logic    grant_dm;
  logic    grant_if;

  // Grant decision; everything is forced idle while reset is held
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (!rst) begin
      grant_dm = bus.dm_req && !(bus.if_ce && (streak == STREAK_SAT));
      grant_if = bus.if_ce && !grant_dm;
    end
  end

  // ROM port drive, MEM grant and IF stall request
  always_comb begin
    bus.rom_ce      = CHIP_DISABLE;
    bus.rom_addr    = ZERO_ADDR;
    bus.dm_gnt      = grant_dm;
    bus.stallreq_if = NO_STOP;
    if (grant_dm) begin
      bus.rom_ce   = CHIP_ENABLE;
      bus.rom_addr = bus.dm_addr;
    end else if (grant_if) begin
      bus.rom_ce   = CHIP_ENABLE;
      bus.rom_addr = bus.if_pc;
    end
    if (!rst && bus.if_ce && !grant_if) begin
      bus.stallreq_if = STOP;
    end
  end

  // Streak counts MEM wins while IF is waiting; any other cycle clears it
  always_comb begin
    streak_nxt = '0;
    if (grant_dm && bus.if_ce) begin
      streak_nxt = (streak == STREAK_SAT) ? streak : streak + STREAK_W'(1);
    end
  end

  // Streak register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end

  // IF capture; flush drops the word fetched on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_inst  <= ZERO_WORD;
      bus.if_valid <= 1'b0;
    end else begin
      bus.if_valid <= grant_if && !bus.flush;
      if (grant_if) begin
        bus.if_inst <= bus.flush ? ZERO_WORD : bus.rom_inst;
      end
    end
  end

  // MEM capture; unaffected by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dm_rdata <= ZERO_WORD;
      bus.dm_ack   <= 1'b0;
    end else begin
      bus.dm_ack <= grant_dm;
      if (grant_dm) begin
        bus.dm_rdata <= bus.rom_inst;
      end
    end
  end

endmodule : rom_port_arbiter

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_rom_port_arbiter;
  import rom_port_arbiter_pkg::*;

  localparam int DM_MAX = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] mem [256];

  rom_port_arbiter_if bus ();

  rom_port_arbiter #(.DM_STREAK_MAX(DM_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational ROM: word indexed by address bits [9:2]
  assign bus.rom_inst = mem[bus.rom_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // waits: how many cycles in a row IF has been pushed back by MEM
  int          m_waits;
  logic [31:0] m_if_inst, m_dm_rdata;
  logic        m_if_valid, m_dm_ack;
  int          p_waits;
  logic [31:0] p_if_inst, p_dm_rdata;
  logic        p_if_valid, p_dm_ack;
  logic        e_dm, e_if, e_stall;
  logic [31:0] e_addr;

  // Per-cycle compare, then work out what the next edge must capture
  always @(negedge clk) begin
    if (rst) begin
      e_dm = 1'b0; e_if = 1'b0; e_stall = 1'b0; e_addr = 32'h0;
    end else begin
      e_dm    = bus.dm_req && !(bus.if_ce && m_waits >= DM_MAX);
      e_if    = bus.if_ce && !e_dm;
      e_stall = bus.if_ce && !e_if;
      e_addr  = e_dm ? bus.dm_addr : (e_if ? bus.if_pc : 32'h0);
    end
    check("dm_gnt",      32'(bus.dm_gnt),      32'(e_dm));
    check("stallreq_if", 32'(bus.stallreq_if), 32'(e_stall));
    check("rom_ce",      32'(bus.rom_ce),      32'(e_dm | e_if));
    check("rom_addr",    bus.rom_addr,         e_addr);
    check("if_valid",    32'(bus.if_valid),    32'(m_if_valid));
    check("if_inst",     bus.if_inst,          m_if_inst);
    check("dm_ack",      32'(bus.dm_ack),      32'(m_dm_ack));
    check("dm_rdata",    bus.dm_rdata,         m_dm_rdata);
    p_if_valid = e_if && !bus.flush;
    p_if_inst  = e_if ? (bus.flush ? 32'h0 : mem[e_addr[9:2]]) : m_if_inst;
    p_dm_ack   = e_dm;
    p_dm_rdata = e_dm ? mem[e_addr[9:2]] : m_dm_rdata;
    p_waits    = (e_dm && bus.if_ce) ? m_waits + 1 : 0;
  end

  // Model state: async clear on reset, otherwise take the pending capture
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_waits = 0; m_if_inst = 32'h0; m_dm_rdata = 32'h0;
      m_if_valid = 1'b0; m_dm_ack = 1'b0;
    end else begin
      m_waits = p_waits; m_if_inst = p_if_inst; m_dm_rdata = p_dm_rdata;
      m_if_valid = p_if_valid; m_dm_ack = p_dm_ack;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] gnt_pat, stall_pat;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
    rst = 1'b1;
    bus.if_ce = 1'b0; bus.if_pc = 32'h0; bus.dm_req = 1'b0;
    bus.dm_addr = 32'h0; bus.flush = 1'b0;
    smp();
    check("reset if_valid", 32'(bus.if_valid), 32'h0);
    check("reset dm_ack",   32'(bus.dm_ack),   32'h0);
    check("reset rom_ce",   32'(bus.rom_ce),   32'h0);
    cyc();

    // Plain fetch from 0x4
    rst = 1'b0; bus.if_ce = 1'b1; bus.if_pc = 32'h4;
    smp();
    check("fetch rom_addr", bus.rom_addr, 32'h4);
    check("fetch stall", 32'(bus.stallreq_if), 32'h0);
    cyc();
    smp();
    check("fetch if_inst", bus.if_inst, 32'hC0DE0001);
    check("fetch if_valid", 32'(bus.if_valid), 32'h1);
    check("fetch rom_addr 2", bus.rom_addr, 32'h4);

    // Single MEM read colliding with fetch
    cyc();
    bus.dm_req = 1'b1; bus.dm_addr = 32'h10;
    smp();
    check("collide dm_gnt", 32'(bus.dm_gnt), 32'h1);
    check("collide stall", 32'(bus.stallreq_if), 32'h1);
    cyc();
    bus.dm_req = 1'b0;
    smp();
    check("collide dm_ack", 32'(bus.dm_ack), 32'h1);
    check("collide dm_rdata", bus.dm_rdata, 32'hC0DE0004);
    check("collide if_valid", 32'(bus.if_valid), 32'h0);

    // Continuous MEM load: D,D,D,I,D,D,D,I
    cyc();
    smp();
    cyc();
    bus.dm_req = 1'b1; bus.dm_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      smp();
      gnt_pat[i]   = bus.dm_gnt;
      stall_pat[i] = bus.stallreq_if;
      if (i < 7) cyc();
    end
    check("streak pattern dm_gnt", 32'(gnt_pat), 32'h77);
    check("streak pattern stall", 32'(stall_pat), 32'h77);
    cyc();
    bus.dm_req = 1'b0;

    // Flush on an IF grant
    smp();
    cyc();
    bus.flush = 1'b1; bus.if_pc = 32'h8;
    smp();
    check("flush pre if_valid", 32'(bus.if_valid), 32'h1);
    cyc();
    bus.flush = 1'b0; bus.if_ce = 1'b0;
    smp();
    check("flush if_valid", 32'(bus.if_valid), 32'h0);
    check("flush if_inst", bus.if_inst, 32'h0);

    // Async reset during a MEM grant
    cyc();
    bus.if_ce = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 32'h20;
    smp();
    check("prerst dm_gnt", 32'(bus.dm_gnt), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst dm_gnt", 32'(bus.dm_gnt), 32'h0);
    check("rst rom_ce", 32'(bus.rom_ce), 32'h0);
    check("rst stall", 32'(bus.stallreq_if), 32'h0);
    check("rst rom_addr", bus.rom_addr, 32'h0);
    check("rst if_valid", 32'(bus.if_valid), 32'h0);
    cyc();
    smp();
    check("rst dm_ack", 32'(bus.dm_ack), 32'h0);
    check("rst rom_ce held", 32'(bus.rom_ce), 32'h0);
    cyc();
    rst = 1'b0; bus.dm_req = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      cyc();
      rst         = ($urandom_range(0, 199) == 0);
      bus.if_ce   = ($urandom_range(0, 3) != 0);
      bus.dm_req  = ($urandom_range(0, 2) != 0);
      bus.if_pc   = $urandom;
      bus.dm_addr = $urandom;
      bus.flush   = ($urandom_range(0, 7) == 0);
    end
    cyc();
    rst = 1'b0; bus.if_ce = 1'b0; bus.dm_req = 1'b0; bus.flush = 1'b0;
    cyc();
    cyc();
    smp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rom_port_arbiter

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single read port of the instruction ROM between two requesters: the IF stage (pc_reg fetch) and the MEM stage (word reads from code space, e.g. literal tables). It sits between pc_reg/mem and inst_rom, grants one requester per cycle, and registers the returned word. It raises a stall request to ctrl whenever a fetch is blocked. A saturating streak counter bounds consecutive MEM grants so fetch cannot starve.

## Interface
Parameters:
- DM_STREAK_MAX, default 3: maximum consecutive MEM grants while IF waits; range 1–7.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- if_ce  in  1  fetch request, `ChipEnable`/`ChipDisable`.
- if_pc  in  `InstAddrBus`  fetch address.
- if_inst  out  `InstBus`  registered fetched instruction.
- if_valid  out  1  if_inst was loaded on the last edge.
- dm_req  in  1  MEM read request.
- dm_addr  in  `InstAddrBus`  MEM read address.
- dm_gnt  out  1  combinational: MEM owns the port this cycle.
- dm_rdata  out  `InstBus`  registered MEM read data.
- dm_ack  out  1  dm_rdata was loaded on the last edge.
- flush  in  1  from ctrl; discards the fetch result captured on this edge.
- stallreq_if  out  1  to ctrl: `Stop` when if_ce is high and IF is not granted.
- rom_ce  out  1  to inst_rom ce.
- rom_addr  out  `InstAddrBus`  to inst_rom addr.
- rom_inst  in  `InstBus`  from inst_rom; combinational, valid in the same cycle.

## Operation
- Arbitration is combinational each cycle:
  - grant_dm = dm_req && !(if_ce && streak == DM_STREAK_MAX)
  - grant_if = if_ce && !grant_dm
  - Default priority goes to MEM. IF wins only when the streak is saturated.
- ROM port:
  - rom_ce = `ChipEnable` iff a grant is active.
  - rom_addr = dm_addr on grant_dm, if_pc on grant_if, otherwise `ZeroWord`.
  - Addresses pass through unmodified; inst_rom applies word indexing.
- IF capture:
  - On grant_if && !flush: if_inst <= rom_inst, if_valid <= 1.
  - On grant_if && flush: if_inst <= `ZeroWord`, if_valid <= 0.
  - With no IF grant: if_valid <= 0 and if_inst holds.
- MEM capture:
  - On grant_dm: dm_rdata <= rom_inst, dm_ack <= 1.
  - Otherwise dm_ack <= 0 and dm_rdata holds.
  - flush does not affect the MEM path.
- Streak counter (3 bits):
  - Increments, saturating at DM_STREAK_MAX, when grant_dm && if_ce.
  - Clears to 0 on any other cycle, including grant_if and cycles where IF is idle.
- stallreq_if = if_ce && !grant_if; it depends on no registered state other than streak.
- MEM handshake: the requester drops dm_req in the cycle after dm_gnt. If dm_req is still high in that cycle, it is a new, back-to-back read.
- While rst is high:
  - All grants are forced low.
  - rom_ce = `ChipDisable`, rom_addr = `ZeroWord`.
  - stallreq_if = `NoStop`, dm_gnt = 0.

## Timing
- Reset values (asynchronous): if_inst = `ZeroWord`, if_valid = 0, dm_rdata = `ZeroWord`, dm_ack = 0, streak = 0.
- Latency: a grant in cycle N drives the ROM in cycle N; data and valid/ack appear in cycle N+1.
- Sustained rate: one read per cycle total. IF receives at least 1 of every DM_STREAK_MAX+1 cycles under continuous MEM load.
- Simultaneous if_ce && dm_req with streak < MAX: MEM is granted and stallreq_if is asserted in the same cycle.
- flush together with a stall: nothing is captured; if_valid = 0 next cycle.
- rst asserted mid-transfer: a pending ack/valid is lost. The requester reissues after reset.

## Structure
- Add the following to defines.v, alongside `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`/`ChipDisable`, `Stop`/`NoStop`:
  - `DmStreakMax` (default 3)
  - `StreakBus` (2:0)
- The block is flat with no sub-module. The arbitration logic is too small to split out.

## Test plan
- Reset released, if_ce=1, if_pc=0x4, dm_req=0 → rom_addr=0x4 every cycle; next cycle if_inst=mem[1], if_valid=1, stallreq_if=0.
- if_ce=1 and a single-cycle dm_req at dm_addr=0x10 → dm_gnt=1, stallreq_if=1 that cycle; dm_ack=1 with dm_rdata=mem[4] next cycle; no if_valid that cycle.
- dm_req held high and if_ce high for 8 cycles, MAX=3 → grant pattern D,D,D,I,D,D,D,I; stallreq_if high on each D cycle.
- flush asserted on an IF grant cycle → next cycle if_valid=0, if_inst=0x00000000.
- rst asserted asynchronously while dm_gnt=1 → outputs clear immediately; dm_ack stays 0; rom_ce=0 until rst is released.
